// File: rtl/bus_master_ctrl_if.sv
// Simple request/ready bus between a master and a slave.
// The master holds valid, read, addr and write_data; the slave answers with ready and read_data.
interface bus_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              valid;
    logic              read;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              ready;
    logic [DATA_W-1:0] read_data;

    modport master (
        output valid, read, addr, write_data,
        input  ready, read_data
    );

    modport slave (
        input  valid, read, addr, write_data,
        output ready, read_data
    );
endinterface

// File: rtl/bus_master_ctrl.sv
// Single-outstanding bus master: accepts a command, runs an address and a data phase
// on busc with a per-phase timeout, then presents one response.
module bus_master_ctrl #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    bus_if.master             busc
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_ADDR_PHASE = 2'b01,
        ST_DATA_PHASE = 2'b10,
        ST_RESP       = 2'b11
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               bus_valid_q;
    logic               bus_read_q;
    logic [ADDR_W-1:0]  bus_addr_q;
    logic [DATA_W-1:0]  bus_wdata_q;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rsp_err_q;

    assign cmd_ready       = (state_q == ST_IDLE);
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_err         = rsp_err_q;
    assign busc.valid      = bus_valid_q;
    assign busc.read       = bus_read_q;
    assign busc.addr       = bus_addr_q;
    assign busc.write_data = bus_wdata_q;

    // Ready always beats the timeout on the same edge; a phase times out after TIMEOUT_CYCLES low-ready cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_read_q  <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        bus_read_q  <= cmd_read;
                        bus_addr_q  <= cmd_addr;
                        bus_wdata_q <= cmd_wdata;
                        bus_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_ADDR_PHASE;
                    end
                end
                ST_ADDR_PHASE: begin
                    if (busc.ready) begin
                        cnt_q   <= '0;
                        state_q <= ST_DATA_PHASE;
                    end else if (cnt_q == TO_LAST) begin
                        bus_valid_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA_PHASE: begin
                    if (busc.ready) begin
                        bus_valid_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= bus_read_q ? busc.read_data : '0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == TO_LAST) begin
                        bus_valid_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    bus_valid_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    rsp_data_q  <= '0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_master_ctrl.sv
// Scoreboard bench for bus_master_ctrl: the stimulus plays the bus slave with planned
// ready delays, and a separate monitor consumes and checks every response.
module tb_bus_master_ctrl;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    always #5 clk = ~clk;

    bus_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_read  (cmd_read),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busc      (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   hold_req = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A phase succeeds if the slave answers within TIMEOUT cycles (w low cycles, then ready).
    function automatic int exp_vcycles(input int w1, input int w2);
        if (w1 > int'(TO) - 1) return int'(TO);
        if (w2 > int'(TO) - 1) return w1 + 1 + int'(TO);
        return w1 + w2 + 2;
    endfunction

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return int'($urandom_range(0, 3));
        if (r < 9) return int'($urandom_range(TO - 2, TO));
        return 255;
    endfunction

    // Issue one command and act as the slave: ready after w1 / w2 low cycles in each phase.
    task automatic do_txn(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] rdata, input int w1, input int w2);
        exp_t e;
        int   vc;
        int   phase;
        int   k;
        int   guard;
        logic bad;
        e.err  = (w1 > int'(TO) - 1) || (w2 > int'(TO) - 1);
        e.data = (e.err || !rd) ? '0 : rdata;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            chk("idle_wait", cmd_ready, 1);
            return;
        end
        chk("gap_valid_low", bus.valid, 0);
        exp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(negedge clk);
        vc = 0; phase = 0; k = 0; guard = 0; bad = 1'b0;
        while (bus.valid && guard < 1000) begin
            vc++;
            guard++;
            if (bus.addr !== addr || bus.read !== rd || bus.write_data !== wdata) bad = 1'b1;
            cmd_valid     = 1'($urandom_range(0, 1));
            cmd_read      = 1'($urandom_range(0, 1));
            cmd_addr      = $urandom;
            cmd_wdata     = $urandom;
            bus.ready     = (phase == 0) ? (k == w1) : (k == w2);
            bus.read_data = bus.ready ? rdata : $urandom;
            @(negedge clk);
            if (bus.ready) begin
                phase++;
                k = 0;
            end else begin
                k++;
            end
        end
        cmd_valid = 1'b0;
        bus.ready = 1'b0;
        chk("bus_fields_stable", bad, 0);
        chk("valid_cycles", vc, exp_vcycles(w1, w2));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Response monitor: drives rsp_ready, checks hold stability and pops the scoreboard.
    initial begin
        logic          prev_v;
        logic [DW-1:0] prev_d;
        logic          prev_e;
        bit            popped;
        int            hold;
        exp_t          e;
        prev_v = 1'b0; prev_d = '0; prev_e = 1'b0; popped = 1'b0; hold = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_v = 1'b0; popped = 1'b0; rsp_ready = 1'b0;
                continue;
            end
            if (popped) begin
                chk("cmd_ready_after_rsp", cmd_ready, 1);
                chk("rsp_valid_drop", rsp_valid, 0);
                popped = 1'b0;
            end
            if (rsp_valid) begin
                if (!prev_v) begin
                    hold = hold_req;
                end else begin
                    chk("rsp_data_hold", rsp_data, prev_d);
                    chk("rsp_err_hold", rsp_err, prev_e);
                end
                chk("cmd_ready_busy", cmd_ready, 0);
                if (hold > 0) begin
                    rsp_ready = 1'b0;
                    hold--;
                end else begin
                    rsp_ready = ($urandom_range(0, 2) != 0);
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", rsp_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_err", rsp_err, e.err);
                    end
                    popped = 1'b1;
                    prev_v = 1'b0;
                end else begin
                    prev_v = 1'b1;
                    prev_d = rsp_data;
                    prev_e = rsp_err;
                end
            end else begin
                prev_v = 1'b0;
                rsp_ready = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int guard;
        reset = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        bus.ready = 1'b0; bus.read_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_bus_valid", bus.valid, 0);
        chk("reset_bus_read", bus.read, 0);
        chk("reset_bus_addr", bus.addr, 0);
        chk("reset_bus_wdata", bus.write_data, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_err", rsp_err, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", cmd_ready, 1);

        do_txn(1'b1, 32'h10, 32'h0, 32'hDEACBEFF, 1, 0);
        do_txn(1'b0, 32'h20, 32'h12345678, $urandom, 0, 0);
        do_txn(1'b1, 32'h30, 32'h0, 32'h55, 255, 0);
        do_txn(1'b1, 32'h34, 32'h0, 32'hA5A5, 0, 255);
        do_txn(1'b1, 32'h40, 32'h0, 32'hCAFE, int'(TO) - 1, int'(TO) - 1);
        do_txn(1'b0, 32'h44, 32'h9, 32'h77, int'(TO), 0);
        hold_req = 5;
        do_txn(1'b1, 32'h50, 32'h0, 32'h1234, 0, 0);
        drain();
        hold_req = 0;

        // Abort a read in its data phase with reset; no response may appear.
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h60; cmd_wdata = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        bus.ready = 1'b1;
        bus.read_data = 32'hBAD0BAD0;
        @(negedge clk);
        chk("abort_in_data_phase", bus.valid, 1);
        bus.ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_bus_valid", bus.valid, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cmd_ready", cmd_ready, 1);
        do_txn(1'b1, 32'h70, 32'h0, 32'h0BADF00D, 0, 1);

        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, pick_wait(), pick_wait());
        end
        drain();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
